// File: rtl/axis_pipe_reg_slice.sv
// axis_pipe_reg_slice: chain of STAGES AXI-Stream register stages.
// MODE=0 registers valid/data/last only (ready is combinational through the chain).
// MODE=1 adds a skid register per stage so ready is also a flop.
// Optional macro AXIS_SLICE_OCC_EN adds the occupancy output and its counter.
module axis_pipe_reg_slice #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned STAGES = 1,
  parameter int unsigned MODE   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] s_in_tdata,
  input  logic              s_in_tlast,
  input  logic              s_in_tvalid,
  output logic              s_in_tready,
  output logic [DWIDTH-1:0] m_out_tdata,
  output logic              m_out_tlast,
  output logic              m_out_tvalid,
`ifdef AXIS_SLICE_OCC_EN
  output logic [$clog2(2*STAGES+1)-1:0] occupancy,
`endif
  input  logic              m_out_tready
);

  localparam int SN = int'(STAGES);

  logic [STAGES-1:0][DWIDTH-1:0] main_data;
  logic [STAGES-1:0]             main_last;
  logic [STAGES-1:0]             main_valid;
  logic [STAGES-1:0][DWIDTH-1:0] in_data;
  logic [STAGES-1:0]             in_last;
  logic [STAGES-1:0]             in_valid;
  logic [STAGES-1:0]             in_ready;
  logic [STAGES-1:0]             out_ready;

  // Stage k is fed by stage k-1 (or the slave port) and drained by stage k+1 (or the master port)
  always_comb begin
    in_data   = '0;
    in_last   = '0;
    in_valid  = '0;
    out_ready = '0;
    in_data[0]     = s_in_tdata;
    in_last[0]     = s_in_tlast;
    in_valid[0]    = s_in_tvalid;
    out_ready[SN-1] = m_out_tready;
    for (int k = 1; k < SN; k++) begin
      in_data[k]      = main_data[k-1];
      in_last[k]      = main_last[k-1];
      in_valid[k]     = main_valid[k-1];
      out_ready[k-1]  = in_ready[k];
    end
  end

  if (MODE == 0) begin : g_fwd

    // Ready ripples back from the master port; a stage is ready when empty or draining
    always_comb begin
      logic nxt;
      in_ready = '0;
      nxt      = m_out_tready;
      for (int k = SN - 1; k >= 0; k--) begin
        nxt         = (~main_valid[k] | nxt) & ~rst;
        in_ready[k] = nxt;
      end
    end

    // Single main register per stage: load on accept, empty when drained without refill
    always_ff @(posedge clk) begin
      if (rst) begin
        main_data  <= '0;
        main_last  <= '0;
        main_valid <= '0;
      end else begin
        for (int k = 0; k < SN; k++) begin
          if (in_valid[k] & in_ready[k]) begin
            main_data[k]  <= in_data[k];
            main_last[k]  <= in_last[k];
            main_valid[k] <= 1'b1;
          end else if (out_ready[k]) begin
            main_valid[k] <= 1'b0;
          end
        end
      end
    end

  end else begin : g_skid

    logic [STAGES-1:0][DWIDTH-1:0] skid_data;
    logic [STAGES-1:0]             skid_last;
    logic [STAGES-1:0]             skid_valid;
    logic [STAGES-1:0]             rdy_q;
    logic [STAGES-1:0]             main_vn;
    logic [STAGES-1:0]             skid_vn;
    logic [STAGES-1:0]             ld_main_in;
    logic [STAGES-1:0]             ld_main_skid;
    logic [STAGES-1:0]             ld_skid;

    assign in_ready = rdy_q;

    // Next occupancy of main/skid per stage and which register loads from where
    always_comb begin
      main_vn      = main_valid;
      skid_vn      = skid_valid;
      ld_main_in   = '0;
      ld_main_skid = '0;
      ld_skid      = '0;
      for (int k = 0; k < SN; k++) begin
        if (skid_valid[k]) begin
          if (out_ready[k]) begin
            ld_main_skid[k] = 1'b1;
            skid_vn[k]      = 1'b0;
          end
        end else if (in_valid[k] & in_ready[k]) begin
          if (~main_valid[k] | out_ready[k]) begin
            ld_main_in[k] = 1'b1;
            main_vn[k]    = 1'b1;
          end else begin
            ld_skid[k] = 1'b1;
            skid_vn[k] = 1'b1;
          end
        end else if (out_ready[k]) begin
          main_vn[k] = 1'b0;
        end
      end
    end

    // Main/skid registers and the registered ready (ready only while the skid will be empty)
    always_ff @(posedge clk) begin
      if (rst) begin
        main_data  <= '0;
        main_last  <= '0;
        main_valid <= '0;
        skid_data  <= '0;
        skid_last  <= '0;
        skid_valid <= '0;
        rdy_q      <= '0;
      end else begin
        main_valid <= main_vn;
        skid_valid <= skid_vn;
        rdy_q      <= ~skid_vn;
        for (int k = 0; k < SN; k++) begin
          if (ld_main_in[k]) begin
            main_data[k] <= in_data[k];
            main_last[k] <= in_last[k];
          end else if (ld_main_skid[k]) begin
            main_data[k] <= skid_data[k];
            main_last[k] <= skid_last[k];
          end
          if (ld_skid[k]) begin
            skid_data[k] <= in_data[k];
            skid_last[k] <= in_last[k];
          end
        end
      end
    end

  end

  assign s_in_tready  = in_ready[0] & ~rst;
  assign m_out_tdata  = main_data[SN-1];
  assign m_out_tlast  = main_last[SN-1];
  assign m_out_tvalid = main_valid[SN-1];

`ifdef AXIS_SLICE_OCC_EN
  localparam int unsigned OW = $clog2(2*STAGES+1);

  logic [OW-1:0] occ_q;
  logic          occ_in_acc;
  logic          occ_out_acc;

  assign occ_in_acc  = s_in_tvalid & s_in_tready;
  assign occ_out_acc = m_out_tvalid & m_out_tready;

  // Beats held: up on accept only, down on emit only
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else if (occ_in_acc & ~occ_out_acc) begin
      occ_q <= occ_q + OW'(1);
    end else if (occ_out_acc & ~occ_in_acc) begin
      occ_q <= occ_q - OW'(1);
    end
  end

  assign occupancy = occ_q;
`endif

endmodule
